mux_n_way_rr: RTL and testbench

MUX_N_WAY_RR -- requirements
Module: mux_n_way_rr

---
 rtl/friscv_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/mux_n_way_rr.sv | 79 +++++++
 tb/tb_mux_n_way_rr.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/friscv_pkg.sv
// rtl/friscv_pkg.sv - shared core-wide constants imported by every block of the core
package friscv_pkg;

    localparam int XLEN      = 32;
    localparam int ILEN      = 32;
    localparam int REG_NUM   = 32;
    localparam int REG_ADDRW = 5;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request picker, searching upward from ptr with wrap-around
module rr_arbiter
    import friscv_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = (int'(ptr) + k) % NUM_CH;
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = en;
                gnt_idx      = SEL_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mux_n_way_rr.sv
// rtl/mux_n_way_rr.sv - N-way round-robin mux into a single registered valid/ready output stage
module mux_n_way_rr
    import friscv_pkg::*;
#(
    parameter int MUX_WIDTH = 32,
    parameter int NUM_CH    = 4,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             valid_in,
    input  logic [NUM_CH*MUX_WIDTH-1:0]   data_in,
    output logic [NUM_CH-1:0]             ready_out,
    output logic                          valid_out,
    output logic [MUX_WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]              sel_out,
    input  logic                          ready_in
);

    logic [SEL_W-1:0]     r_ptr;
    logic                 r_valid;
    logic [MUX_WIDTH-1:0] r_data;
    logic [SEL_W-1:0]     r_sel;

    logic                 w_load_en;
    logic [NUM_CH-1:0]    w_gnt;
    logic [SEL_W-1:0]     w_gnt_idx;
    logic                 w_xfer_in;
    logic [MUX_WIDTH-1:0] w_gnt_data;
    logic [SEL_W-1:0]     w_ptr_next;

    // Reset blocks the grant so nothing is accepted in a reset cycle
    assign w_load_en = (~r_valid | ready_in) & ~rst;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req     (valid_in),
        .ptr     (r_ptr),
        .en      (w_load_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign ready_out = w_gnt;
    assign w_xfer_in = |w_gnt;

    always_comb begin
        w_gnt_data = data_in[MUX_WIDTH-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) begin
                w_gnt_data = data_in[i*MUX_WIDTH +: MUX_WIDTH];
            end
        end
    end

    assign w_ptr_next = (int'(w_gnt_idx) >= NUM_CH - 1) ? '0 : w_gnt_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_xfer_in) begin
            r_ptr   <= w_ptr_next;
            r_valid <= 1'b1;
            r_data  <= w_gnt_data;
            r_sel   <= w_gnt_idx;
        end else if (ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign sel_out   = r_sel;

endmodule

// File: tb/tb_mux_n_way_rr.sv
// tb/tb_mux_n_way_rr.sv - directed and random checks of mux_n_way_rr against a behavioural model
module tb_mux_n_way_rr;

    localparam int W = 32;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     valid_in;
    logic [N*W-1:0]   data_in;
    logic [N-1:0]     ready_out;
    logic             valid_out;
    logic [W-1:0]     data_out;
    logic [1:0]       sel_out;
    logic             ready_in;

    int checks = 0;
    int errors = 0;

    mux_n_way_rr #(.MUX_WIDTH(W), .NUM_CH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    // Model state: the output register contents and the next channel to favour
    int         m_ptr   = 0;
    bit         m_valid = 0;
    logic [W-1:0] m_data = '0;
    int         m_sel   = 0;

    function automatic logic [W-1:0] chan_data(input logic [N*W-1:0] d, input int c);
        return d[c*W +: W];
    endfunction

    // Returns the channel that must be accepted this cycle, or -1
    function automatic int exp_grant(input logic [N-1:0] v, input int p, input bit mv,
                                     input logic rdy, input logic r);
        if (r || (mv && !rdy)) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int g;
        g = exp_grant(valid_in, m_ptr, m_valid, ready_in, rst);
        if (rst) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1; m_data = chan_data(data_in, g); m_sel = g; m_ptr = (g + 1) % N;
        end else if (ready_in) begin
            m_valid = 0;
        end
    end

    // Scoreboard of accepted payloads plus per-cycle comparison against the model
    logic [W-1:0] sb_q[$];
    bit           p_hold = 0;
    logic [W-1:0] p_data;
    logic [1:0]   p_sel;

    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        g  = exp_grant(valid_in, m_ptr, m_valid, ready_in, rst);
        er = (g < 0) ? '0 : N'(1) << g;
        chk("ready_out", 64'(ready_out), 64'(er));
        chk("onehot0", 64'($onehot0(ready_out)), 64'd1);
        chk("valid_out", 64'(valid_out), 64'(m_valid));
        chk("data_out", 64'(data_out), 64'(m_data));
        chk("sel_out", 64'(sel_out), 64'(m_sel));
        chk("no_bad_grant", 64'(ready_out & ~valid_in), 64'd0);
        if (p_hold) begin
            chk("hold_data", 64'(data_out), 64'(p_data));
            chk("hold_sel", 64'(sel_out), 64'(p_sel));
        end
        if (rst) begin
            sb_q.delete();
        end else begin
            if (valid_out && ready_in) begin
                if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                else chk("sb_payload", 64'(data_out), 64'(sb_q.pop_front()));
            end
            for (int i = 0; i < N; i++)
                if (valid_in[i] && ready_out[i]) sb_q.push_back(chan_data(data_in, i));
        end
        p_hold = !rst && valid_out && !ready_in;
        p_data = data_out;
        p_sel  = sel_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] v);
        data_in[c*W +: W] = v;
    endtask

    initial begin
        rst = 1; valid_in = '0; ready_in = 0; data_in = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_ready", 64'(ready_out), 64'd0);
        tick();
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_sel", 64'(sel_out), 64'd0);

        // Full request, no backpressure: channels served 0,1,2,3 back to back
        rst = 0; valid_in = 4'b1111; ready_in = 1;
        for (int i = 0; i < N; i++) set_ch(i, 32'hA0 + i);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("rr_ready", 64'(ready_out), 64'(4'b0001 << k));
            tick();
            chk("rr_valid", 64'(valid_out), 64'd1);
            chk("rr_sel", 64'(sel_out), 64'(k));
            chk("rr_data", 64'(data_out), 64'(32'hA0 + k));
        end
        valid_in = '0;
        tick();
        chk("drain_valid", 64'(valid_out), 64'd0);

        // Backpressure holding channel 2
        valid_in = 4'b0100; set_ch(2, 32'hDEAD);
        tick();
        valid_in = 4'b1111; ready_in = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", 64'(ready_out), 64'd0);
            chk("bp_data", 64'(data_out), 64'h0000DEAD);
            chk("bp_sel", 64'(sel_out), 64'd2);
            tick();
        end

        // Wrap-around from ptr=3
        valid_in = 4'b1001; ready_in = 1;
        @(negedge clk);
        chk("wrap_ch3", 64'(ready_out), 64'b1000);
        tick();
        chk("wrap_sel3", 64'(sel_out), 64'd3);
        @(negedge clk);
        chk("wrap_ch0", 64'(ready_out), 64'b0001);
        tick();
        chk("wrap_sel0", 64'(sel_out), 64'd0);
        @(negedge clk);
        chk("wrap_ptr1", 64'(ready_out), 64'b1000);
        tick();

        // Drain and reload in the same cycle
        valid_in = 4'b0010;
        @(negedge clk);
        chk("dl_ready", 64'(ready_out), 64'b0010);
        tick();
        chk("dl_valid", 64'(valid_out), 64'd1);
        chk("dl_data", 64'(data_out), 64'hA1);
        valid_in = '0; ready_in = 0;
        tick();

        // Reset while holding a payload
        rst = 1; valid_in = 4'b1111; ready_in = 1;
        @(negedge clk);
        chk("mr_ready", 64'(ready_out), 64'd0);
        tick();
        chk("mr_valid", 64'(valid_out), 64'd0);
        chk("mr_data", 64'(data_out), 64'd0);
        rst = 0; valid_in = 4'b1000;
        @(negedge clk);
        chk("mr_ch3", 64'(ready_out), 64'b1000);
        tick();
        chk("mr_sel3", 64'(sel_out), 64'd3);
        rst = 1; tick();
        rst = 0; valid_in = 4'b1111;
        @(negedge clk);
        chk("prio_ch0", 64'(ready_out), 64'b0001);
        tick();

        // Random traffic checked by the model and scoreboard
        for (int c = 0; c < 300; c++) begin
            rst      = ($urandom_range(0, 39) == 0);
            valid_in = N'($urandom());
            ready_in = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) set_ch(i, $urandom());
            tick();
        end
        rst = 0; valid_in = '0; ready_in = 1;
        tick(); tick();
        @(negedge clk);
        chk("end_empty", 64'(sb_q.size()), 64'(valid_out));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
